alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits.
REQ-002 Parameter OPW, default 4, ALU operation-select width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 reqN_valid  input  1  (N=0,1) requester N presents an operation.
REQ-006 reqN_ready  output  1  arbiter accepts requester N's operation this cycle.
REQ-007 reqN_a, reqN_b  input  WIDTH  operands of requester N.
REQ-008 reqN_op  input  OPW  ALU select of requester N (0 = add, 1 = subtract).
REQ-009 respN_valid  output  1  result for requester N is available.
REQ-010 respN_ready  input  1  requester N consumes the result.
REQ-011 resp_result  output  WIDTH  shared result bus, valid when either respN_valid is high.
REQ-012 resp_zero, resp_negative, resp_cout  output  1 each  registered ALU flags for resp_result.
REQ-013 busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, EXEC and RESP.
REQ-015 In IDLE, reqN_ready SHALL be high only for the granted requester; ready SHALL be low in EXEC and RESP.
REQ-016 Grant in IDLE: only one valid -> that requester; both valid -> requester other than last_grant.
REQ-017 last_grant SHALL update only on an accepted transfer (valid && ready).
REQ-018 On acceptance, a, b, op and the owner ID SHALL be registered; the FSM SHALL go IDLE -> EXEC.
REQ-019 In EXEC, the registered operands SHALL drive the ALU; result and flags SHALL be captured at the end of EXEC; the FSM SHALL go EXEC -> RESP.
REQ-020 In RESP, only respN_valid of the owner SHALL be high; result and flags SHALL remain stable until respN_ready.
REQ-021 RESP -> IDLE SHALL occur on owner respN_ready; with no ready, the FSM SHALL stay in RESP indefinitely.
REQ-022 Latency SHALL be: accept at cycle T -> respN_valid high at T+2; throughput at most one operation per 3 cycles.
REQ-023 The arithmetic width SHALL be WIDTH; subtraction SHALL yield a-b modulo 2^WIDTH with flags exactly as produced by the ALU.
REQ-024 The op code SHALL be passed to the ALU unchanged; unused codes SHALL not alter the FSM flow.
REQ-025 respN_valid SHALL never be high for both requesters in the same cycle.
REQ-026 A requester that drops reqN_valid before acceptance SHALL simply lose the grant, with no state change.

Reset
REQ-027 While rst_n=0: state IDLE, last_grant=1 (so req0 wins the first tie), all respN_valid=0, busy=0.
REQ-028 While rst_n=0: resp_result=0 and all flags=0.
REQ-029 A reset in EXEC or RESP SHALL discard the in-flight operation with no response issued.

Structure
REQ-030 A shared package alu_pkg SHALL hold the state enum, op constants ALU_ADD=0 and ALU_SUB=1, and a flags struct (zero, negative, cout).
REQ-031 The existing alu module SHALL be instantiated once as the sole sub-module; its ports SHALL be a, b, sel, result, zero, negative and cout.

Verification
REQ-032 req0 a=14, b=5, op=0, accepted at T -> resp0_valid at T+2, result 19, zero=0, negative=0.
REQ-033 Both valid after reset: req0 6-6 op=1, req1 2+5 -> req0 served first with result 0, zero=1; then req1 with result 7.
REQ-034 Both valid continuously for 4 transfers -> grants alternate 0,1,0,1.
REQ-035 resp0_ready held low 3 cycles in RESP -> result and flags stable, req1_ready stays 0, busy=1.
REQ-036 rst_n pulsed low during EXEC -> resp valids 0 immediately; the next tie is granted to req0.
REQ-037 req1 6-10 op=1 -> result 0xFFFFFFFC; flags match the ALU's outputs exactly.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the two-requester ALU arbiter and its ALU.
// Op codes beyond XOR are legal and make the ALU pass operand a through.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int unsigned ALU_ADD = 0;
  localparam int unsigned ALU_SUB = 1;
  localparam int unsigned ALU_AND = 2;
  localparam int unsigned ALU_OR  = 3;
  localparam int unsigned ALU_XOR = 4;

  typedef struct packed {
    logic zero;
    logic negative;
    logic cout;
  } alu_flags_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU: add/sub with carry-out, bitwise ops, pass-through of a otherwise.
// For subtraction cout is the carry of a + ~b + 1, i.e. 1 when no borrow occurred.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OPW-1:0]   sel,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             cout
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum    = '0;
    result = a;
    cout   = 1'b0;
    case (sel)
      OPW'(ALU_ADD): begin
        sum    = {1'b0, a} + {1'b0, b};
        result = sum[WIDTH-1:0];
        cout   = sum[WIDTH];
      end
      OPW'(ALU_SUB): begin
        sum    = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        result = sum[WIDTH-1:0];
        cout   = sum[WIDTH];
      end
      OPW'(ALU_AND): result = a & b;
      OPW'(ALU_OR):  result = a | b;
      OPW'(ALU_XOR): result = a ^ b;
      default:       result = a;
    endcase
  end

  assign zero     = (result == '0);
  assign negative = result[WIDTH-1];

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end sharing one ALU: round-robin grant on ties, one
// operation in flight, result held on a shared bus until the owner consumes it.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_zero,
  output logic             resp_negative,
  output logic             resp_cout,
  output logic             busy
);

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             owner_q, owner_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [OPW-1:0]   op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;
  alu_flags_t       flags_q, flags_d;

  logic [1:0]       req_valid, req_ready, resp_valid, resp_ready;
  logic [WIDTH-1:0] req_a  [2];
  logic [WIDTH-1:0] req_b  [2];
  logic [OPW-1:0]   req_op [2];

  logic             grant_any, grant_id;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero, alu_negative, alu_cout;

  assign req_valid  = {req1_valid, req0_valid};
  assign resp_ready = {resp1_ready, resp0_ready};
  assign req_a[0]   = req0_a;
  assign req_a[1]   = req1_a;
  assign req_b[0]   = req0_b;
  assign req_b[1]   = req1_b;
  assign req_op[0]  = req0_op;
  assign req_op[1]  = req1_op;

  // A lone requester always wins; on a tie the one not served last time wins.
  always_comb begin
    grant_any = |req_valid;
    grant_id  = (&req_valid) ? ~last_grant_q : req_valid[1];
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign req_ready[gi]  = (state_q == IDLE) && grant_any && (grant_id == 1'(gi));
    assign resp_valid[gi] = (state_q == RESP) && (owner_q == 1'(gi));
  end

  assign req0_ready  = req_ready[0];
  assign req1_ready  = req_ready[1];
  assign resp0_valid = resp_valid[0];
  assign resp1_valid = resp_valid[1];

  alu #(
    .WIDTH (WIDTH),
    .OPW   (OPW)
  ) u_alu (
    .a        (a_q),
    .b        (b_q),
    .sel      (op_q),
    .result   (alu_result),
    .zero     (alu_zero),
    .negative (alu_negative),
    .cout     (alu_cout)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    result_d     = result_q;
    flags_d      = flags_q;
    case (state_q)
      IDLE: begin
        // The granted requester is always valid, so any grant is an acceptance.
        if (grant_any) begin
          owner_d      = grant_id;
          last_grant_d = grant_id;
          a_d          = req_a[grant_id];
          b_d          = req_b[grant_id];
          op_d         = req_op[grant_id];
          state_d      = EXEC;
        end
      end
      EXEC: begin
        result_d         = alu_result;
        flags_d.zero     = alu_zero;
        flags_d.negative = alu_negative;
        flags_d.cout     = alu_cout;
        state_d          = RESP;
      end
      RESP: begin
        if (resp_ready[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      result_q     <= '0;
      flags_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      result_q     <= result_d;
      flags_q      <= flags_d;
    end
  end

  assign resp_result   = result_q;
  assign resp_zero     = flags_q.zero;
  assign resp_negative = flags_q.negative;
  assign resp_cout     = flags_q.cout;
  assign busy          = (state_q != IDLE);

endmodule
